toggle_sync_rx_mc: RTL and testbench

Multi-channel, parametrised receive half of a toggle synchroniser, clocked in the destination domain. Each channel takes a level-toggle signal from a foreign clock domain and passes it through a configurable synchroniser chain. It converts every detected toggle into a one-cycle pulse and into a queued event that is held in a saturating per-channel counter until downstream consumes it with a valid/ready handshake. The block sits at the destination edge of every crossing whose source side flips a register once per event.

---
 rtl/toggle_sync_rx_mc.sv | 72 +++++++
 tb/tb_toggle_sync_rx_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_sync_rx_mc.sv
// Destination-domain receiver for toggle-encoded events. Each channel
// synchronises a toggle level, emits a one-cycle pulse and queues events in a saturating counter.
module toggle_sync_rx_mc #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                      clk_b,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       toggle_in,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [CHANNELS*CNT_W-1:0] evt_count,
  output logic [CHANNELS-1:0]       overflow,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic                      any_valid
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   det, pop, drop;

    // sync_q[0] is the only flop that sees the asynchronous input.
    always_ff @(posedge clk_b or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_in[c]};
        prev_q  <= sync_q[SYNC_STAGES-1];
        pulse_q <= det;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
      end
    end

    always_comb begin
      det   = sync_q[SYNC_STAGES-1] ^ prev_q;
      pop   = (cnt_q != '0) && evt_ready[c];
      drop  = 1'b0;
      cnt_d = cnt_q;
      if (det && !pop) begin
        if (cnt_q == CntMax) drop = 1'b1;
        else                 cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !det) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)            ovf_d = 1'b1;
      else if (ovf_clr[c]) ovf_d = 1'b0;
      else                 ovf_d = ovf_q;
    end

    assign pulse_out[c]                = pulse_q;
    assign evt_valid[c]                = (cnt_q != '0);
    assign overflow[c]                 = ovf_q;
    assign evt_count[c*CNT_W +: CNT_W] = cnt_q;
  end

  assign any_valid = |evt_valid;

endmodule

// File: tb/tb_toggle_sync_rx_mc.sv
// Directed bench for toggle_sync_rx_mc: expected values queued at stimulus time,
// popped and compared on the falling edge.
module tb_toggle_sync_rx_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 4 channels, 2 stages, 2-bit counters (capacity 3).
  logic [3:0] tog_a, rdy_a, clr_a, pulse_a, valid_a, ovf_a;
  logic [7:0] cnt_a;
  logic       any_a;
  // Sweep instances with 3 stages.
  logic [7:0]  tog_b, rdy_b, clr_b, pulse_b, valid_b, ovf_b;
  logic [31:0] cnt_b;
  logic        any_b;
  logic [0:0]  tog_c, rdy_c, clr_c, pulse_c, valid_c, ovf_c;
  logic [3:0]  cnt_c;
  logic        any_c;

  toggle_sync_rx_mc #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(2)) u_a (
    .clk_b(clk), .rst(rst), .toggle_in(tog_a), .pulse_out(pulse_a), .evt_valid(valid_a),
    .evt_ready(rdy_a), .evt_count(cnt_a), .overflow(ovf_a), .ovf_clr(clr_a), .any_valid(any_a)
  );
  toggle_sync_rx_mc #(.CHANNELS(8), .SYNC_STAGES(3), .CNT_W(4)) u_b (
    .clk_b(clk), .rst(rst), .toggle_in(tog_b), .pulse_out(pulse_b), .evt_valid(valid_b),
    .evt_ready(rdy_b), .evt_count(cnt_b), .overflow(ovf_b), .ovf_clr(clr_b), .any_valid(any_b)
  );
  toggle_sync_rx_mc #(.CHANNELS(1), .SYNC_STAGES(3), .CNT_W(4)) u_c (
    .clk_b(clk), .rst(rst), .toggle_in(tog_c), .pulse_out(pulse_c), .evt_valid(valid_c),
    .evt_ready(rdy_c), .evt_count(cnt_c), .overflow(ovf_c), .ovf_clr(clr_c), .any_valid(any_c)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    tog_a = '0; rdy_a = '0; clr_a = '0;
    tog_b = '0; rdy_b = '0; clr_b = '0;
    tog_c = '0; rdy_c = '0; clr_c = '0;

    // Reset state
    push("rst_pulse", 0); push("rst_valid", 0); push("rst_cnt", 0);
    push("rst_ovf", 0);   push("rst_any", 0);   push("rst_cnt_b", 0);
    tick(2);
    pop_check(64'(pulse_a)); pop_check(64'(valid_a)); pop_check(64'(cnt_a));
    pop_check(64'(ovf_a));   pop_check(64'(any_a));   pop_check(64'(cnt_b));
    rst = 1'b0;
    tick(2);

    // Single event on ch0: pulse only after the 3rd edge
    tog_a[0] = 1'b1;
    push("single_p1", 0); push("single_p2", 0);
    push("single_p3", 64'h1); push("single_cnt", 64'h01); push("single_valid", 64'h1);
    push("single_any", 1); push("single_p4", 0);
    tick(1); pop_check(64'(pulse_a));
    tick(1); pop_check(64'(pulse_a));
    tick(1); pop_check(64'(pulse_a)); pop_check(64'(cnt_a)); pop_check(64'(valid_a));
    pop_check(64'(any_a));
    tick(1); pop_check(64'(pulse_a));

    // Burst on ch1 with stalled consumer, then drain
    tog_a[1] = 1'b1; tick(4);
    tog_a[1] = 1'b0; tick(4);
    tog_a[1] = 1'b1;
    push("burst_cnt3", 64'h0D); push("burst_valid", 64'h3);
    tick(4); pop_check(64'(cnt_a)); pop_check(64'(valid_a));
    rdy_a[1] = 1'b1;
    push("drain_2", 64'h09); push("drain_1", 64'h05); push("drain_0", 64'h01);
    push("drain_valid", 64'h1); push("ready_no_valid", 64'h01);
    tick(1); pop_check(64'(cnt_a));
    tick(1); pop_check(64'(cnt_a));
    tick(1); pop_check(64'(cnt_a)); pop_check(64'(valid_a));
    tick(1); pop_check(64'(cnt_a));
    rdy_a[1] = 1'b0;

    // ch2: detect and pop in the same cycle leaves count at 1
    tog_a[2] = 1'b1;
    push("simul_pre", 64'h11);
    tick(4); pop_check(64'(cnt_a));
    tog_a[2] = 1'b0;
    tick(2);
    rdy_a[2] = 1'b1;
    push("simul_pulse", 64'h4); push("simul_cnt", 64'h11); push("simul_ovf", 0);
    tick(1); pop_check(64'(pulse_a)); pop_check(64'(cnt_a)); pop_check(64'(ovf_a));
    rdy_a[2] = 1'b0;
    push("simul_cnt_after", 64'h11);
    tick(1); pop_check(64'(cnt_a));

    // ch3 overflow with CNT_W=2
    for (int i = 0; i < 4; i++) begin
      tog_a[3] = ~tog_a[3];
      tick(4);
    end
    push("ovf_cnt", 64'hD1); push("ovf_flag", 64'h8);
    pop_check(64'(cnt_a)); pop_check(64'(ovf_a));
    tog_a[3] = ~tog_a[3];
    tick(2);
    clr_a[3] = 1'b1;
    push("ovf_set_wins", 64'h8); push("ovf_sat", 64'hD1);
    tick(1); pop_check(64'(ovf_a)); pop_check(64'(cnt_a));
    clr_a[3] = 1'b0;
    tick(1);
    clr_a[3] = 1'b1;
    push("ovf_clear", 0);
    tick(1); pop_check(64'(ovf_a));
    clr_a[3] = 1'b0;

    // Asynchronous reset mid-operation with a toggle in flight
    tog_a = 4'b0000;
    tick(1);
    #2 rst = 1'b1;
    push("mid_pulse", 0); push("mid_valid", 0); push("mid_cnt", 0);
    push("mid_ovf", 0);   push("mid_any", 0);
    #1;
    pop_check(64'(pulse_a)); pop_check(64'(valid_a)); pop_check(64'(cnt_a));
    pop_check(64'(ovf_a));   pop_check(64'(any_a));
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("post_rst_pulse", 0);
      tick(1); pop_check(64'(pulse_a));
    end
    push("post_rst_cnt", 0);
    pop_check(64'(cnt_a));

    // Sweep: 3 stages give 4-edge latency; channels independent
    tog_b[5] = 1'b1;
    tog_c[0] = 1'b1;
    push("sweep_b_p3", 0); push("sweep_c_p3", 0);
    push("sweep_b_p4", 64'h20); push("sweep_c_p4", 1);
    push("sweep_b_cnt", 64'h0010_0000); push("sweep_b_valid", 64'h20);
    push("sweep_c_cnt", 1); push("sweep_b_p5", 0);
    tick(3); pop_check(64'(pulse_b)); pop_check(64'(pulse_c));
    tick(1); pop_check(64'(pulse_b)); pop_check(64'(pulse_c));
    pop_check(64'(cnt_b)); pop_check(64'(valid_b)); pop_check(64'(cnt_c));
    tick(1); pop_check(64'(pulse_b));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
